// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: framed host byte stream into RAM, then releases the CPU.
// Frame is len_hi, len_lo, payload[len], 8-bit sum of payload; CPU stays in reset until a good frame.
module program_loader #(
  parameter int ADDRESS_SIZE = 11,
  parameter int BASE_ADDR    = 'h400,
  parameter int MAX_BYTES    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    cpu_hold,
  output logic                    cpu_start,
  output logic [ADDRESS_SIZE-1:0] pc_init,
  output logic                    done,
  output logic                    error
);

  localparam logic [ADDRESS_SIZE-1:0] BASE    = ADDRESS_SIZE'(BASE_ADDR);
  localparam logic [15:0]             MAX_LEN = 16'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                    state_q, state_d;
  logic                      in_ready_q;
  logic                      mem_we_q;
  logic [ADDRESS_SIZE-1:0]   mem_addr_q;
  logic [7:0]                mem_wdata_q;
  logic                      cpu_hold_q;
  logic                      cpu_start_q;
  logic                      done_q;
  logic                      error_q;
  logic [15:0]               len_q;
  logic [10:0]               count_q;
  logic [7:0]                sum_q;

  logic                      accept;
  logic [15:0]               len_full;
  logic                      last_data;

  assign accept    = in_valid && in_ready_q;
  assign len_full  = {len_q[15:8], in_data};
  assign last_data = ({5'b0, count_q} + 16'd1) == len_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full > MAX_LEN)    state_d = S_ERROR;
          else if (len_full == 16'd0) state_d = S_CHECK;
          else                        state_d = S_DATA;
        end
      end
      S_DATA:  if (accept && last_data) state_d = S_CHECK;
      S_CHECK: if (accept) state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      cpu_start_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      len_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CHECK);
      mem_we_q    <= 1'b0;
      cpu_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            count_q    <= '0;
            sum_q      <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
          end
        end
        S_LEN_HI: if (accept) len_q[15:8] <= in_data;
        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= in_data;
            if (state_d == S_ERROR) error_q <= 1'b1;
          end
        end
        S_DATA: begin
          // Address is taken from count before it advances: first byte lands at BASE.
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= BASE + ADDRESS_SIZE'(count_q);
            mem_wdata_q <= in_data;
            count_q     <= count_q + 11'd1;
            sum_q       <= sum_q + in_data;
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (state_d == S_DONE) begin
              done_q      <= 1'b1;
              cpu_hold_q  <= 1'b0;
              cpu_start_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign cpu_start = cpu_start_q;
  assign pc_init   = BASE;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed bench for program_loader with hand-computed expectations.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic [10:0] pc_init;
  logic        done;
  logic        error;

  program_loader #(.ADDRESS_SIZE(11), .BASE_ADDR('h400), .MAX_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .pc_init(pc_init), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write/start monitor, sampled mid-cycle.
  int          cyc = 0;
  logic [10:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          n_start = 0;
  int          hold_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (cpu_start) begin
      n_start++;
      if (cpu_hold) hold_bad++;
    end
  end

  logic [7:0] frame[$];
  int base_w;
  int base_s;
  int ready_drops;

  task automatic mark();
    base_w = wa.size();
    base_s = n_start;
    ready_drops = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(negedge clk);
      if (!in_ready) ready_drops++;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) send_byte(frame[i], gap);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [7:0] d0, input int step, input int spacing);
    check({tag, "_nwr"}, wa.size() - base_w, n);
    for (int i = 0; i < n; i++) begin
      if (base_w + i < wa.size()) begin
        check({tag, "_addr"}, wa[base_w+i], 11'h400 + 11'(i));
        check({tag, "_data"}, wd[base_w+i], 8'(d0 + 8'(i * step)));
        if (spacing > 0 && i > 0)
          check({tag, "_spacing"}, wc[base_w+i] - wc[base_w+i-1], spacing);
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"},  in_ready, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_hold"},  cpu_hold, 1);
    check({tag, "_cpu_start"}, cpu_start, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_error"},     error, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_reset("rst");
    check("pc_init", pc_init, 11'h400);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_ready", in_ready, 0);

    // Basic load.
    mark(); do_start();
    frame = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_frame(0);
    check_writes("basic", 4, 8'h01, 1, 1);
    check("basic_start_pulses", n_start - base_s, 1);
    check("basic_done", done, 1);
    check("basic_hold", cpu_hold, 0);
    check("basic_error", error, 0);
    check("basic_ready_done", in_ready, 0);

    // Same frame with 2-cycle valid gaps.
    mark(); do_start();
    check("gap_done_cleared", done, 0);
    check("gap_hold_set", cpu_hold, 1);
    send_frame(2);
    check_writes("gap", 4, 8'h01, 1, 3);
    check("gap_ready_drops", ready_drops, 0);
    check("gap_start_pulses", n_start - base_s, 1);
    check("gap_done", done, 1);

    // Bad checksum: sum(FF,01) = 00, host sends 01.
    mark(); do_start();
    frame = '{8'h00, 8'h02, 8'hFF, 8'h01, 8'h01};
    send_frame(0);
    check("bad_nwr", wa.size() - base_w, 2);
    check("bad_error", error, 1);
    check("bad_done", done, 0);
    check("bad_hold", cpu_hold, 1);
    check("bad_start_pulses", n_start - base_s, 0);

    // Recovery with a good single-byte frame.
    mark(); do_start();
    check("rec_error_cleared", error, 0);
    frame = '{8'h00, 8'h01, 8'h55, 8'h55};
    send_frame(0);
    check_writes("rec", 1, 8'h55, 0, 0);
    check("rec_done", done, 1);
    check("rec_error", error, 0);

    // Over-length 0x0401.
    mark(); do_start();
    frame = '{8'h04, 8'h01};
    send_frame(0);
    check("len401_error", error, 1);
    check("len401_nwr", wa.size() - base_w, 0);
    check("len401_ready", in_ready, 0);
    check("len401_hold", cpu_hold, 1);

    // Over-length 0xFFFF.
    mark(); do_start();
    frame = '{8'hFF, 8'hFF};
    send_frame(0);
    check("lenffff_error", error, 1);
    check("lenffff_nwr", wa.size() - base_w, 0);

    // Maximum length: 1024 x 01, checksum 00.
    mark(); do_start();
    frame = '{8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) frame.push_back(8'h01);
    frame.push_back(8'h00);
    send_frame(0);
    check("max_nwr", wa.size() - base_w, 1024);
    if (wa.size() > 0) begin
      check("max_last_addr", wa[wa.size()-1], 11'h7FF);
      check("max_last_data", wd[wd.size()-1], 8'h01);
    end
    check("max_first_addr", (base_w < wa.size()) ? {21'b0, wa[base_w]} : 32'hFFFF, 11'h400);
    check("max_done", done, 1);
    check("max_error", error, 0);

    // Zero length.
    mark(); do_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("zero_nwr", wa.size() - base_w, 0);
    check("zero_done", done, 1);
    check("zero_start_pulses", n_start - base_s, 1);

    // Reset after 2 of 4 payload bytes.
    mark(); do_start();
    frame = '{8'h00, 8'h04, 8'h01, 8'h02};
    foreach (frame[i]) send_byte(frame[i], 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_idle_reset("midrst");
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_ready_idle", in_ready, 0);
    in_valid = 1'b0;
    check("midrst_nwr", wa.size() - base_w, 2);
    check("midrst_start_pulses", n_start - base_s, 0);

    // start during DATA is ignored.
    mark(); do_start();
    frame = '{8'h00, 8'h04, 8'h01, 8'h02};
    foreach (frame[i]) send_byte(frame[i], 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ign_ready", in_ready, 1);
    frame = '{8'h03, 8'h04, 8'h0A};
    send_frame(0);
    check_writes("ign", 4, 8'h01, 1, 0);
    check("ign_done", done, 1);
    check("ign_error", error, 0);
    check("ign_start_pulses", n_start - base_s, 1);

    check("hold_low_at_start", hold_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
